// File: rtl/rram_sched.sv
// rram_sched: round-robin scheduler that time-shares the single RRAM compute
// mux unit between NREQ requesters. Each grant latches one 4 x 8-bit operand
// vector, issues it with a one-cycle start pulse, waits the unit latency,
// captures the result and returns it tagged with the owning requester index.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid       per-requester "operand vector pending"
//   req_data        requester i at [32i+31:32i]; byte k feeds vrd(k+1)
//   req_ready       one-hot grant (combinational, IDLE only, 0 during reset)
//   mu_vrd_o        operand register driven onto the mux unit
//   mu_start        one-cycle start pulse to the mux unit
//   mu_res_i        mux unit results; byte k is vrd(k+1)_o
//   resp_valid      captured result available
//   resp_id         requester index owning the result
//   resp_data       captured result
//   resp_ready      consumer accepts the result
//   busy            an operation is in flight (state is not IDLE)
module rram_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mu_vrd_o,
  output logic                 mu_start,
  input  logic [31:0]          mu_res_i,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  input  logic                 resp_ready,
  output logic                 busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   opnd_q, opnd_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   res_q, res_d;

  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  scan_idx;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % int'(NREQ));
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Next-state, register updates and the combinational grant.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    id_d      = id_q;
    res_d     = res_q;
    req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = !rst;
          opnd_d   = req_data[int'(grant_idx)*int'(DW) +: DW];
          id_d     = grant_idx;
          rr_ptr_d = IDW'((int'(grant_idx) + 1) % int'(NREQ));
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter reaching zero marks the cycle the unit's result is valid.
        if (cnt_q == '0) begin
          res_d   = mu_res_i;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      id_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      id_q     <= id_d;
      res_q    <= res_d;
    end
  end

  // Outputs decode straight from registers, so reset clears them at once.
  assign mu_vrd_o   = opnd_q;
  assign mu_start   = (state_q == S_ISSUE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = id_q;
  assign resp_data  = res_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rram_sched.sv
// Bench for rram_sched: transaction-level model (cycles since grant) checked
// every cycle against a NREQ=4/LAT=2 instance, plus directed literal checks
// and a NREQ=1/LAT=1 instance checked against its fixed 4-cycle cadence.
module tb_rram_sched;

  localparam int N = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance signals
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*32-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [31:0]    mu_vrd_o;
  logic           mu_start;
  logic [31:0]    mu_res_i;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [31:0]    resp_data;
  logic           resp_ready;
  logic           busy;

  // Single-requester instance signals
  logic [0:0]     rv1;
  logic [31:0]    rd1;
  logic [0:0]     rdy1;
  logic [31:0]    vrd1;
  logic           start1;
  logic [31:0]    res1;
  logic           rvalid1;
  logic [0:0]     rid1;
  logic [31:0]    rdata1;
  logic           rready1;
  logic           busy1;

  rram_sched #(.NREQ(N), .LAT(L)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .mu_vrd_o(mu_vrd_o), .mu_start(mu_start),
    .mu_res_i(mu_res_i), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy)
  );

  rram_sched #(.NREQ(1), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_data(rd1),
    .req_ready(rdy1), .mu_vrd_o(vrd1), .mu_start(start1),
    .mu_res_i(res1), .resp_valid(rvalid1), .resp_id(rid1),
    .resp_data(rdata1), .resp_ready(rready1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Mux unit results change every cycle so a mistimed capture is visible.
  always @(posedge clk) begin
    #1;
    mu_res_i = $urandom;
    res1     = $urandom;
  end

  // Behavioural model: an operation is described only by cycles since grant.
  int           m_active, m_rel, m_ptr, m_id, g;
  logic [31:0]  m_vrd, m_res;
  logic [N-1:0] exp_rdy;
  int           grant_log[$];

  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_rel = 0; m_ptr = 0; m_id = 0; m_vrd = '0; m_res = '0;
    end
    g = rr_pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (!rst && m_active == 0 && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready",  req_ready,  exp_rdy);
    chk("mu_start",   mu_start,   (m_active != 0 && m_rel == 1));
    chk("resp_valid", resp_valid, (m_active != 0 && m_rel >= L + 2));
    chk("busy",       busy,       (m_active != 0));
    chk("mu_vrd_o",   mu_vrd_o,   m_vrd);
    chk("resp_id",    resp_id,    m_id);
    chk("resp_data",  resp_data,  m_res);
    if (!rst) begin
      if (m_active != 0) begin
        if (m_rel == L + 1) m_res = mu_res_i;
        if (m_rel >= L + 2 && resp_ready) m_active = 0;
        else m_rel++;
      end else if (g >= 0) begin
        m_active = 1;
        m_rel    = 1;
        m_vrd    = req_data[g*32 +: 32];
        m_id     = g;
        m_ptr    = (g + 1) % N;
        grant_log.push_back(g);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [31:0] res_exp;
  logic [31:0] r1;
  logic        seen;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1;
    rv1 = 1'b1; rd1 = 32'hCAFEF00D; rready1 = 1'b1;
    mu_res_i = '0; res1 = '0;
    repeat (3) smp();
    req_valid = '1;
    smp();
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);

    // Single request from requester 2; it drops and changes data after grant
    step();
    rst = 1'b0;
    req_valid = 4'b0100;
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_data[95:64] = 32'hA1B2C3D4;
    smp();
    chk("t1_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    req_data[95:64] = 32'h5555AAAA;
    smp();
    chk("t1_start", mu_start, 1'b1);
    chk("t1_vrd", mu_vrd_o, 32'hA1B2C3D4);
    smp();
    smp();
    res_exp = mu_res_i;
    smp();
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_resp_id", resp_id, 2'd2);
    chk("t1_resp_data", resp_data, res_exp);
    chk("t1_vrd_hold", mu_vrd_o, 32'hA1B2C3D4);

    // All requesters valid: grants rotate from 0 after reset
    step(); rst = 1'b1;
    step(); rst = 1'b0; req_valid = '1; resp_ready = 1'b1;
    grant_log.delete();
    for (int i = 0; i < 200 && grant_log.size() < 8; i++) smp();
    if (grant_log.size() < 8) begin
      chk("rr_timeout", 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < 8; i++) chk("rr_order", grant_log[i], i % 4);
    end

    // Back-pressure in RESP
    step(); resp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin smp(); seen = resp_valid; end
    chk("bp_reach_resp", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_resp_valid", resp_valid, 1'b1);
      chk("bp_busy", busy, 1'b1);
      chk("bp_req_ready", req_ready, 4'b0000);
      chk("bp_data", resp_data, m_res);
    end
    step(); resp_ready = 1'b1;
    smp();
    chk("bp_last_resp", resp_valid, 1'b1);
    smp();
    chk("bp_idle", busy, 1'b0);
    chk("bp_regrant", (req_ready != '0), 1'b1);
    smp();
    chk("bp_next_start", mu_start, 1'b1);

    // Reset in WAIT aborts the operation
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin smp(); seen = mu_start; end
    chk("rw_reach_issue", seen, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chk("rw_req_ready", req_ready, 4'b0000);
    chk("rw_mu_start", mu_start, 1'b0);
    chk("rw_vrd", mu_vrd_o, 32'h0);
    chk("rw_resp_valid", resp_valid, 1'b0);
    chk("rw_resp_id", resp_id, 2'd0);
    chk("rw_resp_data", resp_data, 32'h0);
    chk("rw_busy", busy, 1'b0);
    step(); step();
    rst = 1'b0; req_valid = '0;
    for (int i = 0; i < L + 4; i++) begin
      smp();
      chk("rw_no_resp", resp_valid, 1'b0);
    end
    step(); req_valid = 4'b1111;
    smp();
    chk("rw_regrant0", req_ready, 4'b0001);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      req_valid = N'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom};
      resp_ready = ($urandom_range(0, 3) != 0);
    end

    // NREQ=1, LAT=1 with continuous request: one operation every 4 cycles
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    r1 = '0;
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("n1_req_ready", rdy1, (i % 4 == 0));
      chk("n1_start", start1, (i % 4 == 1));
      chk("n1_resp_valid", rvalid1, (i % 4 == 3));
      chk("n1_busy", busy1, (i % 4 != 0));
      chk("n1_resp_id", rid1, 1'b0);
      if (i % 4 != 0) chk("n1_vrd", vrd1, 32'hCAFEF00D);
      if (i % 4 == 2) r1 = res1;
      if (i % 4 == 3) chk("n1_resp_data", rdata1, r1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rram_sched.md
# rram_sched

Round-robin scheduler that shares the single RRAM compute mux unit between `NREQ` requesters. It accepts one 4-lane × 8-bit operand vector per grant and drives it onto the mux unit's `vrd1..vrd4` inputs with a one-cycle start pulse. It then waits the unit's fixed latency, captures `vrd1_o..vrd4_o` and returns the result tagged with the requester index. It sits between the vector issue logic and the mux unit, and is the only block that drives the mux unit.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be ≥ 1.
- `LAT`, 2: cycles from the `mu_start` cycle to valid `mu_res_i`; must be ≥ 1.
- `IDW`, `$clog2(NREQ)` (min 1): width of the requester id.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `req_valid`  in  NREQ  — requester i has an operand vector pending.
- `req_data`  in  NREQ*32  — requester i at [32i+31:32i]; byte k at [8k+7:8k] maps to `vrd(k+1)`.
- `req_ready`  out  NREQ  — one-hot grant; a handshake occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `mu_vrd_o`  out  32  — operands to the mux unit; byte k drives `vrd(k+1)`.
- `mu_start`  out  1  — one-cycle start pulse to the mux unit.
- `mu_res_i`  in  32  — mux unit results; byte k is `vrd(k+1)_o`.
- `resp_valid`  out  1  — result available.
- `resp_id`  out  IDW  — index of the requester that owns the result.
- `resp_data`  out  32  — captured result.
- `resp_ready`  in  1  — consumer accepts the result.
- `busy`  out  1  — high when the state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid`, go to ISSUE.
  - ISSUE: go to WAIT.
  - WAIT: go to RESP when the counter reaches 0.
  - RESP: go to IDLE on `resp_ready`.
- Arbitration, IDLE only:
  - The grant `g` is the first index with `req_valid` high, searching from `rr_ptr` upward with wrap modulo NREQ.
  - `req_ready[g]` is combinational, high only in IDLE, and forced to 0 while `rst` is high.
- On the grant edge:
  - Latch `req_data` slice `g` into the operand register.
  - Latch `g` into the id register.
  - Set `rr_ptr <= (g+1) mod NREQ`.
- ISSUE: `mu_start`=1 for exactly one cycle; load the wait counter with LAT-1.
- `mu_vrd_o` always shows the operand register, so it stays stable through ISSUE, WAIT and RESP.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, capture `mu_res_i` into the result register.
- RESP:
  - `resp_valid`=1, with `resp_id` and `resp_data` from registers.
  - Held stable until `resp_ready`.
  - On the handshake edge go to IDLE; no grant is issued in that same cycle.
- Only one operation is in flight; no new request is accepted until the response has been handed off.
- `req_valid` changes after the grant have no effect, because the operands are already latched.
- Reset values: state=IDLE, `rr_ptr`=0, counter=0, all registers 0. Outputs `req_ready`=0, `mu_start`=0, `mu_vrd_o`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `busy`=0.
- Reset during ISSUE, WAIT or RESP aborts the operation; no response is produced and a late `mu_res_i` is ignored.

## Timing
- Grant handshake at edge of cycle 0:
  - ISSUE in cycle 1 (`mu_start`=1).
  - WAIT in cycles 2..LAT+1; capture at the end of cycle LAT+1.
  - `resp_valid` rises in cycle LAT+2.
- Minimum request-to-request spacing is LAT+3 cycles (`resp_ready` held high).
- `resp_ready` low stalls in RESP indefinitely; data does not change.
- When all requesters are valid continuously, grants go 0,1,2,…,NREQ-1,0. No requester waits more than NREQ-1 other operations.
- With NREQ=1, requester 0 is always granted; `rr_ptr` stays 0.

## Test plan
- Reset released, single request: `req_valid`=4'b0100, `req_data[95:64]`=32'hA1B2C3D4, LAT=2, `resp_ready`=1.
  - Required: `req_ready`=4'b0100 at cycle 0 and `mu_start` in cycle 1 with `mu_vrd_o`=32'hA1B2C3D4.
  - Required: `resp_valid` in cycle 4 with `resp_id`=2 and `resp_data` equal to the model `mu_res_i` at cycle 3.
- All four requesters held valid for 8 operations: grant order 0,1,2,3,0,1,2,3; each `resp_id` matches its grant.
- Back-pressure: `resp_ready`=0 for 5 cycles in RESP.
  - Required: `resp_valid`, `resp_id` and `resp_data` are constant, `busy`=1 and `req_ready`=0.
  - Required: the handshake edge returns to IDLE, and the next grant comes one cycle later.
- Requester drops `req_valid` and changes `req_data` right after its grant: `mu_vrd_o` keeps the latched value; the response is still delivered.
- Assert `rst` during WAIT: all outputs go to 0 immediately; no `resp_valid` appears; the next grant restarts from `rr_ptr`=0.
- LAT=1, and NREQ=1 with continuous `req_valid`: `resp_valid` at cycle 3; one operation every 4 cycles; `resp_id` always 0.
